// File: rtl/mem_arb2.sv
// Two-port round-robin arbiter in front of a single-ported, combinationally read memory.
// Optional address range check enabled by defining MEM_ARB_ADDR_CHECK_EN.
module mem_arb2 #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_wr0,
    input  logic        i_wr1,
    input  logic [15:0] i_addr0,
    input  logic [15:0] i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic [15:0] o_rdata0,
    output logic [15:0] o_rdata1,
    output logic        o_err0,
    output logic        o_err1,
    output logic        o_mem_wr,
    output logic        o_mem_rd,
    output logic [15:0] o_mem_address,
    output logic [15:0] o_mem_data,
    input  logic [15:0] i_mem_data,
    output logic        o_busy
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          state, state_d;
    logic            prio, prio_d;          // port that wins the next tie
    logic            cmd_port, cmd_port_d;
    logic            cmd_wr, cmd_wr_d;
    logic            cmd_err, cmd_err_d;
    logic [AW-1:0]   cmd_addr, cmd_addr_d;
    logic [DW-1:0]   cmd_wdata, cmd_wdata_d;
    logic            ack0_d, ack1_d, err0_d, err1_d;
    logic            mem_wr_d, mem_rd_d;
    logic [DW-1:0]   rdata0_d, rdata1_d;
    logic            grant_port;
    logic            sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_err;
    logic [DW-1:0]   rd_value;

    // Next state, command capture and registered output values
    always_comb begin
        state_d     = state;
        prio_d      = prio;
        cmd_port_d  = cmd_port;
        cmd_wr_d    = cmd_wr;
        cmd_err_d   = cmd_err;
        cmd_addr_d  = cmd_addr;
        cmd_wdata_d = cmd_wdata;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        rdata0_d    = o_rdata0;
        rdata1_d    = o_rdata1;

        grant_port = (i_req0 && i_req1) ? prio : i_req1;
        sel_wr     = grant_port ? i_wr1    : i_wr0;
        sel_addr   = grant_port ? i_addr1  : i_addr0;
        sel_wdata  = grant_port ? i_wdata1 : i_wdata0;
        sel_err    = ADDR_CHECK && (32'(sel_addr) >= MEM_WORDS);
        rd_value   = cmd_err ? DW'(0) : i_mem_data;

        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    state_d     = ACCESS;
                    prio_d      = ~grant_port;
                    cmd_port_d  = grant_port;
                    cmd_wr_d    = sel_wr;
                    cmd_err_d   = sel_err;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    mem_wr_d    = sel_wr && !sel_err;
                    mem_rd_d    = !sel_wr;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (cmd_port) begin
                    ack1_d = 1'b1;
                    err1_d = cmd_err;
                    if (!cmd_wr) begin
                        rdata1_d = rd_value;
                    end
                end else begin
                    ack0_d = 1'b1;
                    err0_d = cmd_err;
                    if (!cmd_wr) begin
                        rdata0_d = rd_value;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cmd_port  <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            o_ack0    <= 1'b0;
            o_ack1    <= 1'b0;
            o_err0    <= 1'b0;
            o_err1    <= 1'b0;
            o_mem_wr  <= 1'b0;
            o_mem_rd  <= 1'b0;
            o_rdata0  <= '0;
            o_rdata1  <= '0;
        end else begin
            state     <= state_d;
            prio      <= prio_d;
            cmd_port  <= cmd_port_d;
            cmd_wr    <= cmd_wr_d;
            cmd_err   <= cmd_err_d;
            cmd_addr  <= cmd_addr_d;
            cmd_wdata <= cmd_wdata_d;
            o_ack0    <= ack0_d;
            o_ack1    <= ack1_d;
            o_err0    <= err0_d;
            o_err1    <= err1_d;
            o_mem_wr  <= mem_wr_d;
            o_mem_rd  <= mem_rd_d;
            o_rdata0  <= rdata0_d;
            o_rdata1  <= rdata1_d;
        end
    end

    assign o_mem_address = cmd_addr;
    assign o_mem_data    = cmd_wdata;
    assign o_busy        = (state == ACCESS);

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: transaction-level reference model with per-cycle compare plus directed scenarios.
module tb_mem_arb2;

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, wr0, wr1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, mem_wr, mem_rd, busy;
    logic [15:0] rdata0, rdata1, mem_address, mem_data, mem_q;

    int n_checks = 0;
    int n_errs   = 0;
    int wr_cnt   = 0;

    logic [15:0] phys_mem [0:1023];
    logic [15:0] ref_mem  [0:1023];

    always #5 clk = ~clk;

    mem_arb2 #(.MEM_WORDS(1024)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_err0(err0), .o_err1(err1), .o_mem_wr(mem_wr), .o_mem_rd(mem_rd),
        .o_mem_address(mem_address), .o_mem_data(mem_data),
        .i_mem_data(mem_q), .o_busy(busy)
    );

    // Memory behind the arbiter: combinational read, write on the clock edge
    assign mem_q = phys_mem[mem_address[9:0]];
    always @(posedge clk) begin
        if (mem_wr) phys_mem[mem_address[9:0]] = mem_data;
    end

    function automatic logic [15:0] init_val(input int i);
        return (i == 5) ? 16'h1234 : 16'(i * 7 + 16'h0100);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending transaction at a time, completes one edge after its grant
    bit          m_busy, m_port, m_wr, m_err, m_prio;
    logic [15:0] m_addr, m_wdata;
    bit          e_ack0, e_ack1, e_err0, e_err1;
    logic [15:0] e_rdata0, e_rdata1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_prio = 0; m_port = 0; m_wr = 0; m_err = 0;
            m_addr = 0; m_wdata = 0;
            e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
            e_rdata0 = 16'h0000; e_rdata1 = 16'h0000;
        end else begin
            e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
            if (m_busy) begin
                if (m_port) begin
                    e_ack1 = 1; e_err1 = m_err;
                    if (!m_wr) e_rdata1 = m_err ? 16'h0000 : ref_mem[m_addr[9:0]];
                end else begin
                    e_ack0 = 1; e_err0 = m_err;
                    if (!m_wr) e_rdata0 = m_err ? 16'h0000 : ref_mem[m_addr[9:0]];
                end
                if (m_wr && !m_err) ref_mem[m_addr[9:0]] = m_wdata;
                m_busy = 0;
            end else if (req0 || req1) begin
                m_port  = (req0 && req1) ? m_prio : req1;
                m_prio  = !m_port;
                m_wr    = m_port ? wr1 : wr0;
                m_addr  = m_port ? addr1 : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                m_err   = CHECK && (int'(m_addr) >= 1024);
                m_busy  = 1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (mem_wr) wr_cnt++;
        chk("ack0", 16'(ack0), 16'(e_ack0));
        chk("ack1", 16'(ack1), 16'(e_ack1));
        chk("err0", 16'(err0), 16'(e_err0));
        chk("err1", 16'(err1), 16'(e_err1));
        chk("rdata0", rdata0, e_rdata0);
        chk("rdata1", rdata1, e_rdata1);
        chk("busy", 16'(busy), 16'(m_busy));
        chk("mem_wr", 16'(mem_wr), 16'(m_busy && m_wr && !m_err));
        chk("mem_rd", 16'(mem_rd), 16'(m_busy && !m_wr));
        if (m_busy) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_data", mem_data, m_wdata);
        end
    end

    task automatic do_access(input bit port, input bit wr, input logic [15:0] addr,
                             input logic [15:0] data, output int lat, output bit err);
        lat = 0;
        err = 0;
        if (port) begin
            req1 = 1; wr1 = wr; addr1 = addr; wdata1 = data;
        end else begin
            req0 = 1; wr0 = wr; addr0 = addr; wdata0 = data;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((port && ack1) || (!port && ack0)) begin
                lat = c;
                err = port ? err1 : err0;
                break;
            end
        end
        #1;
        req0 = 0;
        req1 = 0;
        chk("ack_seen", 16'(lat != 0), 16'h0001);
    endtask

    int          lat;
    bit          aerr;
    logic [15:0] saved;
    int          order[$];
    int          last_c;

    initial begin
        rst_n = 0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = init_val(i);
            ref_mem[i]  = init_val(i);
        end

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_mem_address", mem_address, 16'h0000);
        #1 rst_n = 1;

        // Single read on port 0
        saved = rdata1;
        do_access(0, 0, 16'h0005, 16'h0000, lat, aerr);
        chk("rd_latency", 16'(lat), 16'd2);
        chk("rd_rdata0", rdata0, 16'h1234);
        chk("rd_rdata1_kept", rdata1, saved);

        // Write then read on port 1
        wr_cnt = 0;
        do_access(1, 1, 16'h03FF, 16'hBEEF, lat, aerr);
        chk("wr_latency", 16'(lat), 16'd2);
        chk("wr_strobe_cycles", 16'(wr_cnt), 16'd1);
        chk("wr_rdata1_kept", rdata1, 16'h0000);
        do_access(1, 0, 16'h03FF, 16'h0000, lat, aerr);
        chk("wr_rb_rdata1", rdata1, 16'hBEEF);
        chk("wr_rb_rdata0_kept", rdata0, 16'h1234);

        // Contention from reset: grants alternate starting with port 0
        @(negedge clk);
        #1 rst_n = 0;
        req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 16'h0001; addr1 = 16'h0002;
        @(negedge clk);
        #1 rst_n = 1;
        last_c = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                order.push_back(ack1 ? 1 : 0);
                if (order.size() > 1) chk("rr_ack_gap", 16'(c - last_c), 16'd2);
                last_c = c;
                if (order.size() == 4) break;
            end
        end
        #1 req0 = 0; req1 = 0;
        chk("rr_ack_count", 16'(order.size()), 16'd4);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 16'(order[i]), 16'(i % 2));
        chk("rr_rdata0", rdata0, 16'h0107);
        chk("rr_rdata1", rdata1, 16'h010E);

        // Reset during a write access aborts it
        @(negedge clk);
        #1 req0 = 1; wr0 = 1; addr0 = 16'h0010; wdata0 = 16'hDEAD;
        @(negedge clk);
        chk("abort_wr_before", 16'(mem_wr), 16'h0001);
        #1 rst_n = 0;
        #1;
        chk("abort_wr_drop", 16'(mem_wr), 16'h0000);
        chk("abort_busy_drop", 16'(busy), 16'h0000);
        req0 = 0;
        @(negedge clk);
        chk("abort_no_ack", 16'(ack0), 16'h0000);
        @(negedge clk);
        #1 rst_n = 1;
        do_access(0, 0, 16'h0010, 16'h0000, lat, aerr);
        chk("abort_old_value", rdata0, 16'h0170);

        // Out-of-range write
        wr_cnt = 0;
        do_access(0, 1, 16'h0400, 16'hAAAA, lat, aerr);
        chk("oob_err", 16'(aerr), 16'(CHECK));
        chk("oob_strobe_cycles", 16'(wr_cnt), CHECK ? 16'd0 : 16'd1);
        do_access(0, 0, 16'h0000, 16'h0000, lat, aerr);
        chk("oob_word0", rdata0, CHECK ? 16'h0100 : 16'hAAAA);
        if (CHECK) begin
            do_access(0, 0, 16'h0400, 16'h0000, lat, aerr);
            chk("oob_rd_err", 16'(aerr), 16'h0001);
            chk("oob_rd_zero", rdata0, 16'h0000);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
